// File: rtl/reg_pipeline_pkg.sv
// Shared constants and helpers for the reg_pipeline delay line and the blocks that instantiate it.
package reg_pipeline_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Width of a counter that must hold every value from 0 to depth inclusive.
    function automatic int OCC_W(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_pipeline_stage.sv
// One data+valid register of the delay line: sync reset, flush and clock enable.
module reg_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q       <= RST_VAL;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/reg_pipeline.sv
// Stallable, flushable WIDTH x DEPTH register delay line with per-stage valid bits.
// Define REG_PIPELINE_OCC_EN to add the occ port and its incremental occupancy counter.
module reg_pipeline
    import reg_pipeline_pkg::*;
#(
    parameter int               WIDTH   = DEFAULT_WIDTH,
    parameter int               DEPTH   = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
`ifdef REG_PIPELINE_OCC_EN
    ,
    output logic [OCC_W(DEPTH)-1:0] occ
`endif
);

    // Entry 0 is the pipeline input; entry i+1 is the output of stage i.
    logic [DEPTH:0][WIDTH-1:0] chain_data;
    logic [DEPTH:0]            chain_vld;

    assign chain_data[0] = d;
    assign chain_vld[0]  = d_valid;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        reg_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .en      (en),
            .d       (chain_data[i]),
            .d_valid (chain_vld[i]),
            .q       (chain_data[i+1]),
            .q_valid (chain_vld[i+1])
        );
    end

    assign q       = chain_data[DEPTH];
    assign q_valid = chain_vld[DEPTH];

`ifdef REG_PIPELINE_OCC_EN
    localparam int               OW      = OCC_W(DEPTH);
    localparam logic [OW-1:0]    OCC_MAX = OW'(DEPTH);

    // Only an enabled edge where the entering and leaving valid bits differ moves the count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ <= '0;
        end else if (en) begin
            if (d_valid && !q_valid && occ != OCC_MAX) begin
                occ <= occ + 1'b1;
            end else if (!d_valid && q_valid && occ != '0) begin
                occ <= occ - 1'b1;
            end
        end
    end
`else
    // Occupancy tracking is compiled out; the stages alone carry the state.
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Self-checking bench for reg_pipeline: vector table, hand sequences and a randomised run against a queue model.
module tb_reg_pipeline;
    import reg_pipeline_pkg::*;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_VAL = 8'hA5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             d_valid = 1'b0;
    logic [WIDTH-1:0] q;
    logic             q_valid;
`ifdef REG_PIPELINE_OCC_EN
    logic [OCC_W(DEPTH)-1:0] occ;
`endif

    int checks = 0;
    int failures = 0;

    reg_pipeline #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .q_valid (q_valid)
`ifdef REG_PIPELINE_OCC_EN
        ,
        .occ     (occ)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the pipeline contents as a queue, newest item at the front.
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             vld;
    } item_t;

    item_t model_q[$];

    function automatic void modelClear();
        item_t blank;
        blank.data = RST_VAL;
        blank.vld  = 1'b0;
        model_q.delete();
        for (int i = 0; i < DEPTH; i++) model_q.push_back(blank);
    endfunction

    function automatic int modelOcc();
        int n = 0;
        foreach (model_q[i]) if (model_q[i].vld) n++;
        return n;
    endfunction

    task automatic applyStimulus(input logic r, input logic f, input logic e,
                                 input logic dv, input logic [WIDTH-1:0] dd);
        item_t it;
        @(negedge clk);
        rst = r; flush = f; en = e; d_valid = dv; d = dd;
        @(posedge clk);
        if (r || f) begin
            modelClear();
        end else if (e) begin
            it.data = dd;
            it.vld  = dv;
            model_q.push_front(it);
            void'(model_q.pop_back());
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_q,
                               input logic exp_qv, input int exp_occ);
        checks++;
        if (q !== exp_q) begin
            failures++;
            $display("[TB] FAIL %s q: got %h expected %h", name, q, exp_q);
        end
        checks++;
        if (q_valid !== exp_qv) begin
            failures++;
            $display("[TB] FAIL %s q_valid: got %b expected %b", name, q_valid, exp_qv);
        end
`ifdef REG_PIPELINE_OCC_EN
        checks++;
        if ($isunknown(occ) || int'(occ) != exp_occ) begin
            failures++;
            $display("[TB] FAIL %s occ: got %0d expected %0d", name, occ, exp_occ);
        end
`else
        if (exp_occ < 0) $display("[TB] note: negative occupancy expectation in %s", name);
`endif
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, model_q[DEPTH-1].data, model_q[DEPTH-1].vld, modelOcc());
    endtask

    typedef struct {
        logic             rst, flush, en, dv;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_q;
        logic             exp_qv;
        int               exp_occ;
    } vec_t;

    vec_t vecs[21];

    initial begin
        logic bub[12];

        // rst, flush, en, dv, d, exp_q, exp_qv, exp_occ
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hA5, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'hA5, 1'b0, 1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'hA5, 1'b0, 2};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'hA5, 1'b0, 3};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 8'h01, 1'b1, 4};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 8'h02, 1'b1, 4};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 8'h02, 1'b1, 4};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 1'b1, 3};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 8'hA5, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 8'hA5, 1'b0, 1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 8'hA5, 1'b0, 1};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h10, 1'b1, 1};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h20, 1'b0, 0};
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 8'hA5, 1'b0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 8'hA5, 1'b0, 1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0, 1};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 1};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 8'hA5, 1'b0, 0};

        modelClear();
        for (int i = 0; i < 21; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].en, vecs[i].dv, vecs[i].d);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_qv, vecs[i].exp_occ);
        end

        // Stall: fill with 1..4, hold for three cycles, then step once.
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'(i));
        checkOutput("stall_full", 8'h01, 1'b1, 4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE);
            checkOutput($sformatf("stall_hold%0d", i), 8'h01, 1'b1, 4);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("stall_release", 8'h02, 1'b1, 3);

        // Bubbles: q_valid replays d_valid DEPTH enabled edges later.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checkOutput("bubble_flush", 8'hA5, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            bub[i] = (i % 2 == 0);
            applyStimulus(1'b0, 1'b0, 1'b1, bub[i], 8'(8'hC0 + i));
            if (i >= DEPTH - 1)
                checkOutput($sformatf("bubble%0d", i), 8'(8'hC0 + i - (DEPTH - 1)),
                            bub[i-(DEPTH-1)], 2);
        end

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 24) == 0,
                          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          8'($urandom));
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
